arc_mem_arbiter: RTL and testbench

- Shares the ARC softcore's single memory bus between two requesters: instruction fetch (IF) and data load/store (D).
- Sequences each bus transaction as select, wait for ack, then wait for ack release.
- Ack is multi-cycle and level-style, up to several clocks wide.
- Sits between the datapath/control unit and the system memory/peripheral interface inside system.

---
 rtl/arc_mem_pkg.sv | 18 +
 rtl/arc_mem_rr_arb.sv | 35 +++
 rtl/arc_mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_arc_mem_arbiter.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arc_mem_pkg.sv
// Shared types and defaults for the ARC memory bus arbiter.
package arc_mem_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_t;

endpackage

// File: rtl/arc_mem_rr_arb.sv
// Two-way round-robin arbiter between instruction fetch (req[0]) and data (req[1]).
module arc_mem_rr_arb
  import arc_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant_en,
  output grant_t     gnt,
  output logic       valid
);

  grant_t last_grant;

  // On contention, the port that did not win last time gets the bus.
  always_comb begin
    gnt   = GNT_IF;
    valid = |req;
    case (req)
      2'b01:   gnt = GNT_IF;
      2'b10:   gnt = GNT_D;
      2'b11:   gnt = (last_grant == GNT_D) ? GNT_IF : GNT_D;
      default: gnt = GNT_IF;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= GNT_D;
    end else if (grant_en && valid) begin
      last_grant <= gnt;
    end
  end

endmodule

// File: rtl/arc_mem_arbiter.sv
// Shares the single ARC memory bus between fetch and data ports: select, wait ack, wait ack release.
// Optional watchdog abort of a stuck ACCESS is enabled with `define ARC_MEM_TIMEOUT_EN.
module arc_mem_arbiter
  import arc_mem_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          busy,
  output logic          err
);

  state_t     state;
  grant_t     owner;
  grant_t     arb_gnt;
  logic       arb_valid;
  logic       grant_en;
  logic [1:0] arb_req;

  assign arb_req  = {d_req, if_req};
  assign grant_en = (state == ST_IDLE);

  arc_mem_rr_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (arb_req),
    .grant_en (grant_en),
    .gnt      (arb_gnt),
    .valid    (arb_valid)
  );

`ifdef ARC_MEM_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            err_q;
  logic            wd_expired;

  assign wd_expired = (wd_cnt == WD_LAST);
  assign err        = err_q;
`else
  assign err = 1'b0;

  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  // Bus registers are loaded only at grant, so requester inputs may change freely during ACCESS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      owner     <= GNT_D;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      busy      <= 1'b0;
`ifdef ARC_MEM_TIMEOUT_EN
      wd_cnt    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
`ifdef ARC_MEM_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            owner  <= arb_gnt;
            mem_cs <= 1'b1;
            busy   <= 1'b1;
            state  <= ST_ACCESS;
            if (arb_gnt == GNT_IF) begin
              mem_addr  <= if_addr;
              mem_we    <= 1'b0;
              mem_wdata <= '0;
            end else begin
              mem_addr  <= d_addr;
              mem_we    <= d_we;
              mem_wdata <= d_wdata;
            end
          end
        end

        ST_ACCESS: begin
          if (mem_ack) begin
            if (!mem_we) begin
              if (owner == GNT_IF) if_rdata <= mem_rdata;
              else                 d_rdata  <= mem_rdata;
            end
            if (owner == GNT_IF) if_done <= 1'b1;
            else                 d_done  <= 1'b1;
            mem_cs <= 1'b0;
            state  <= ST_RELEASE;
`ifdef ARC_MEM_TIMEOUT_EN
            wd_cnt <= '0;
          end else if (wd_expired) begin
            if (owner == GNT_IF) if_done <= 1'b1;
            else                 d_done  <= 1'b1;
            err_q  <= 1'b1;
            mem_cs <= 1'b0;
            state  <= ST_RELEASE;
            wd_cnt <= '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
        end

        // A multi-cycle ack must fully drop before the bus can be granted again.
        ST_RELEASE: begin
          if (!mem_ack) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          mem_cs <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arc_mem_arbiter.sv
// Scoreboard bench for arc_mem_arbiter; define ARC_MEM_TIMEOUT_EN to exercise the watchdog with TIMEOUT=8.
module tb_arc_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef ARC_MEM_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          mem_cs;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          busy;
  logic          err;

  typedef struct {
    bit            port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  int vectors;
  int miscompares;

  logic          s_if_done, s_d_done, s_err, s_cs;
  logic [DW-1:0] s_if_rdata, s_d_rdata;
  int            extra_done;
  int            cs_seen;

  arc_mem_arbiter #(
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cs(output int n);
    bit ok;
    n  = 0;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n++;
      if (mem_cs) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL wait_cs: mem_cs=%b after %0d cycles, required 1", mem_cs, n);
    end
  endtask

  // Bus model: ack `delay` cycles after the call, snapshot outputs one edge after the first ack.
  task automatic ack_start(input int delay, input logic [DW-1:0] rd);
    repeat (delay) step();
    mem_ack   = 1'b1;
    mem_rdata = rd;
    step();
    s_if_done  = if_done;
    s_d_done   = d_done;
    s_err      = err;
    s_cs       = mem_cs;
    s_if_rdata = if_rdata;
    s_d_rdata  = d_rdata;
  endtask

  task automatic ack_finish(input int width);
    extra_done = 0;
    cs_seen    = 0;
    for (int i = 1; i < width; i++) begin
      step();
      if (if_done || d_done) extra_done++;
      if (mem_cs) cs_seen++;
    end
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    int n;
    apply_reset();
    rst = 1'b0;
    repeat (2) step();
    vectors++;
    if ({mem_cs, mem_we, busy, if_done, d_done, err, mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: cs=%b we=%b busy=%b ifd=%b dd=%b err=%b addr=%h ifr=%h dr=%h, required all 0",
               mem_cs, mem_we, busy, if_done, d_done, err, mem_addr, if_rdata, d_rdata);
    end
    rst = 1'b1;
    step();
    if_req  = 1'b1;
    if_addr = 32'h40;
    wait_cs(n);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_pre_busy: busy=%b, required 1", busy);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({mem_cs, busy, if_done, d_done} !== 4'b0 || mem_addr !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_async_abort: cs=%b busy=%b ifd=%b dd=%b addr=%h, required all 0",
               mem_cs, busy, if_done, d_done, mem_addr);
    end
    if_req = 1'b0;
    step();
    rst = 1'b1;
    step();
    vectors++;
    if (busy !== 1'b0 || mem_cs !== 1'b0 || if_done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_idle_after: busy=%b cs=%b ifd=%b, required 0 0 0", busy, mem_cs, if_done);
    end
  endtask

  task automatic test_if_read();
    int n;
    exp_q.push_back('{port: 0, we: 1'b0, addr: 32'h100, wdata: '0, rdata: 32'hDEADBEEF});
    if_req  = 1'b1;
    if_addr = 32'h100;
    wait_cs(n);
    vectors++;
    if (n !== 1) begin
      miscompares++;
      $display("[TB] FAIL if_req_to_cs: latency=%0d, required 1", n);
    end
    cur = exp_q[0];
    vectors++;
    if (mem_addr !== cur.addr || mem_we !== cur.we) begin
      miscompares++;
      $display("[TB] FAIL if_bus: addr=%h we=%b, required %h %b", mem_addr, mem_we, cur.addr, cur.we);
    end
    ack_start(2, 32'hDEADBEEF);
    cur = exp_q.pop_front();
    vectors++;
    if (s_if_done !== 1'b1 || s_d_done !== 1'b0 || s_if_rdata !== cur.rdata || s_err !== 1'b0 || s_cs !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL if_done: ifd=%b dd=%b rdata=%h err=%b cs=%b, required 1 0 %h 0 0",
               s_if_done, s_d_done, s_if_rdata, s_err, s_cs, cur.rdata);
    end
    if_req = 1'b0;
    exp_q.push_back('{port: 1, we: 1'b0, addr: 32'h104, wdata: '0, rdata: 32'h11112222});
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h104;
    ack_finish(2);
    vectors++;
    if (extra_done !== 0 || cs_seen !== 0) begin
      miscompares++;
      $display("[TB] FAIL if_ack_hold: extra_done=%0d cs_cycles=%0d, required 0 0", extra_done, cs_seen);
    end
    wait_cs(n);
    vectors++;
    if (n !== 2) begin
      miscompares++;
      $display("[TB] FAIL release_to_cs: cycles=%0d, required 2", n);
    end
    cur = exp_q[0];
    vectors++;
    if (mem_addr !== cur.addr || mem_we !== cur.we) begin
      miscompares++;
      $display("[TB] FAIL d_read_bus: addr=%h we=%b, required %h %b", mem_addr, mem_we, cur.addr, cur.we);
    end
    ack_start(0, 32'h11112222);
    cur = exp_q.pop_front();
    vectors++;
    if (s_d_done !== 1'b1 || s_if_done !== 1'b0 || s_d_rdata !== cur.rdata || s_if_rdata !== 32'hDEADBEEF) begin
      miscompares++;
      $display("[TB] FAIL d_read_done: dd=%b ifd=%b drdata=%h ifrdata=%h, required 1 0 %h deadbeef",
               s_d_done, s_if_done, s_d_rdata, s_if_rdata, cur.rdata);
    end
    d_req = 1'b0;
    ack_finish(1);
  endtask

  task automatic test_round_robin();
    int n;
    apply_reset();
    exp_q.push_back('{port: 0, we: 1'b0, addr: 32'h140, wdata: '0, rdata: 32'hA5A50001});
    exp_q.push_back('{port: 1, we: 1'b1, addr: 32'h200, wdata: 32'h12345678, rdata: '0});
    if_req = 1'b1; if_addr = 32'h140;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678;
    wait_cs(n);
    cur = exp_q[0];
    vectors++;
    if (mem_addr !== cur.addr || mem_we !== cur.we) begin
      miscompares++;
      $display("[TB] FAIL rr_first_if: addr=%h we=%b, required %h %b", mem_addr, mem_we, cur.addr, cur.we);
    end
    ack_start(1, 32'hA5A50001);
    cur = exp_q.pop_front();
    vectors++;
    if (s_if_done !== 1'b1 || s_d_done !== 1'b0 || s_if_rdata !== cur.rdata) begin
      miscompares++;
      $display("[TB] FAIL rr_if_done: ifd=%b dd=%b rdata=%h, required 1 0 %h", s_if_done, s_d_done, s_if_rdata, cur.rdata);
    end
    if_req = 1'b0;
    ack_finish(1);
    wait_cs(n);
    cur = exp_q[0];
    vectors++;
    if (mem_addr !== cur.addr || mem_we !== cur.we || mem_wdata !== cur.wdata) begin
      miscompares++;
      $display("[TB] FAIL rr_d_write_bus: addr=%h we=%b wdata=%h, required %h %b %h",
               mem_addr, mem_we, mem_wdata, cur.addr, cur.we, cur.wdata);
    end
    d_addr  = 32'h300;
    d_wdata = 32'h0;
    d_we    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (mem_addr !== 32'h200 || mem_wdata !== 32'h12345678 || mem_we !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL stable_bus[%0d]: addr=%h wdata=%h we=%b, required 00000200 12345678 1",
                 i, mem_addr, mem_wdata, mem_we);
      end
    end
    ack_start(0, 32'hBAD0BAD0);
    cur = exp_q.pop_front();
    vectors++;
    if (s_d_done !== 1'b1 || s_d_rdata !== 32'h0 || s_if_rdata !== 32'hA5A50001) begin
      miscompares++;
      $display("[TB] FAIL rr_d_write_done: dd=%b drdata=%h ifrdata=%h, required 1 00000000 a5a50001",
               s_d_done, s_d_rdata, s_if_rdata);
    end
    d_req = 1'b0;
    ack_finish(2);
    exp_q.push_back('{port: 0, we: 1'b0, addr: 32'h180, wdata: '0, rdata: 32'h0000CAFE});
    exp_q.push_back('{port: 1, we: 1'b0, addr: 32'h280, wdata: '0, rdata: 32'h0BADF00D});
    if_req = 1'b1; if_addr = 32'h180;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h280;
    wait_cs(n);
    cur = exp_q[0];
    vectors++;
    if (mem_addr !== cur.addr) begin
      miscompares++;
      $display("[TB] FAIL rr_second_if: addr=%h, required %h", mem_addr, cur.addr);
    end
    ack_start(0, 32'h0000CAFE);
    cur = exp_q.pop_front();
    vectors++;
    if (s_if_done !== 1'b1 || s_if_rdata !== cur.rdata) begin
      miscompares++;
      $display("[TB] FAIL rr_second_if_done: ifd=%b rdata=%h, required 1 %h", s_if_done, s_if_rdata, cur.rdata);
    end
    if_req = 1'b0;
    ack_finish(1);
    wait_cs(n);
    ack_start(0, 32'h0BADF00D);
    cur = exp_q.pop_front();
    vectors++;
    if (s_d_done !== 1'b1 || s_d_rdata !== cur.rdata || mem_addr !== cur.addr) begin
      miscompares++;
      $display("[TB] FAIL rr_second_d_done: dd=%b rdata=%h addr=%h, required 1 %h %h",
               s_d_done, s_d_rdata, mem_addr, cur.rdata, cur.addr);
    end
    d_req = 1'b0;
    ack_finish(1);
  endtask

  task automatic test_idle_ack();
    int spurious;
    spurious = 0;
    repeat (2) step();
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF0000;
    for (int i = 0; i < 3; i++) begin
      step();
      if (if_done || d_done || mem_cs || busy) spurious++;
    end
    mem_ack = 1'b0;
    step();
    vectors++;
    if (spurious !== 0 || d_rdata !== 32'h0BADF00D || if_rdata !== 32'h0000CAFE) begin
      miscompares++;
      $display("[TB] FAIL idle_ack: spurious=%0d drdata=%h ifrdata=%h, required 0 0badf00d 0000cafe",
               spurious, d_rdata, if_rdata);
    end
  endtask

  task automatic test_timeout();
    int n;
    int cs_cycles;
    bit got_done;
    exp_q.push_back('{port: 1, we: 1'b0, addr: 32'h3C0, wdata: '0, rdata: 32'h0BADF00D});
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3C0;
    wait_cs(n);
`ifdef ARC_MEM_TIMEOUT_EN
    cs_cycles = 1;
    got_done  = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (d_done) begin
        got_done = 1;
        break;
      end
      if (mem_cs) cs_cycles++;
    end
    cur = exp_q.pop_front();
    vectors++;
    if (!got_done || cs_cycles !== TB_TIMEOUT || err !== 1'b1 || d_rdata !== cur.rdata || mem_cs !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL timeout_abort: done=%b cs_cycles=%0d err=%b drdata=%h cs=%b, required 1 %0d 1 %h 0",
               got_done, cs_cycles, err, d_rdata, mem_cs, TB_TIMEOUT, cur.rdata);
    end
    d_req = 1'b0;
    repeat (2) step();
`else
    cs_cycles = 0;
    got_done  = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (mem_cs && !d_done && !if_done && !err) cs_cycles++;
    end
    vectors++;
    if (cs_cycles !== 100) begin
      miscompares++;
      $display("[TB] FAIL no_timeout_hold: cs_cycles=%0d, required 100", cs_cycles);
    end
    ack_start(0, 32'h55AA55AA);
    got_done = s_d_done;
    exp_q[0].rdata = 32'h55AA55AA;
    cur = exp_q.pop_front();
    vectors++;
    if (got_done !== 1'b1 || s_d_rdata !== cur.rdata || s_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL late_ack_done: dd=%b drdata=%h err=%b, required 1 %h 0", got_done, s_d_rdata, s_err, cur.rdata);
    end
    d_req = 1'b0;
    ack_finish(1);
    step();
`endif
    vectors++;
    if (exp_q.size() !== 0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: pending=%0d busy=%b, required 0 0", exp_q.size(), busy);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_if_read();
    test_round_robin();
    test_idle_ack();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
